seg_display_source_select: RTL and testbench
============================================

# seg_display_source_select

Upstream feeder for the four-digit seven-segment driver. It chooses one of four 32-bit processor observation values (for example PC, ALU result, register data, cycle count) using a debounced pushbutton. It then samples the chosen value at a slow periodic rate so the digits stay readable, and drives the driver's 13-bit `num` input. Values above 13 bits are saturated and flagged.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000. Number of consecutive cycles the synchronized button must differ from its stable level before the stable level flips. Minimum 2.
- `UPDATE_CYCLES`, default 25_000_000. Period of the periodic display sample. Minimum 2.

Ports:
- `clk`  in  1. System clock.
- `rst`  in  1. Asynchronous, active-low reset.
- `btn`  in  1. Raw pushbutton, asynchronous to `clk`. Active high.
- `freeze`  in  1. Synchronous level. While high, `num` and `sat` hold.
- `src0`, `src1`, `src2`, `src3`  in  32 each. Candidate values.
- `num`  out  13. Value presented to the seven-segment driver.
- `sel`  out  2. Currently selected source index.
- `sat`  out  1. High when the last loaded value exceeded 8191.
- `update`  out  1. One-cycle pulse on every cycle that `num` is loaded.

## Operation
- Synchronizer: `btn` passes through a 2-flop synchronizer to give `btn_s`.
- Debouncer:
  - Keeps a stable level `btn_q` and a counter `db_cnt`.
  - Each cycle that `btn_s != btn_q`, `db_cnt` increments.
  - Each cycle that `btn_s == btn_q`, `db_cnt` clears to 0.
  - When `db_cnt == DEBOUNCE_CYCLES-1` and `btn_s` still differs: `btn_q <= btn_s` and `db_cnt <= 0`.
- Press detect: a rising edge of `btn_q` (`btn_q & ~btn_q_d`) increments `sel` modulo 4 (3 wraps to 0) and sets `load_pend`. Falling edges do nothing.
- Update timer:
  - `upd_cnt` counts 0 to `UPDATE_CYCLES-1` and wraps.
  - Its terminal value produces a periodic load request.
  - `upd_cnt` clears to 0 on any cycle a forced load happens.
- Load: on a load cycle, `num` is set to `src[sel]` if that value is 8191 or less, else to 8191. `sat` is set to (`src[sel]` > 8191). `update` pulses.
- Forced load: when `load_pend` is set and `freeze` is low, a load happens and `load_pend` clears.
- Freeze: while `freeze` is high, no load happens and `update` stays 0.
  - `sel` still advances on presses.
  - `load_pend` stays set while frozen. The first cycle with `freeze` low does the forced load.
  - `upd_cnt` keeps running.
- No state machine beyond the counters. Sources are sampled only on load cycles and are never registered otherwise.

## Timing
- Reset (asynchronous assert, `rst` low): all of the following go to 0 — `num`, `sel`, `sat`, `update`, both synchronizer flops, `btn_q`, `btn_q_d`, `db_cnt`, `upd_cnt`, `load_pend`.
- Button-to-`sel` latency: 2 synchronizer cycles, plus `DEBOUNCE_CYCLES` cycles of stable difference, plus 1 edge-detect cycle.
- `sel`-to-`num` latency: `num` loads from the new `sel` on the clock edge after `sel` changes, provided `freeze` is low.
- Bounce: any glitch shorter than `DEBOUNCE_CYCLES` clears `db_cnt` and has no effect.
- Periodic load: `num` updates on the edge where `upd_cnt == UPDATE_CYCLES-1`, giving one `update` pulse per `UPDATE_CYCLES` cycles.
- Simultaneous periodic terminal and forced load (or `sel` edge) in one cycle:
  - Exactly one load happens that cycle, using the `sel` register value at that edge.
  - A `sel` increment on that same edge sets `load_pend`, so a second load follows one cycle later with the new index.
- Reset mid-debounce or mid-period: all progress is discarded, and counting restarts from 0 after `rst` deasserts.

## Test plan
Run with `DEBOUNCE_CYCLES`=4 and `UPDATE_CYCLES`=8.
- Reset: with `rst` low, drive `src0`=123. Required: `num`=0, `sel`=0, `sat`=0, `update`=0. After release, the first `update` pulse comes on the 8th rising edge and `num`=123.
- Clean press: hold `btn` high for 10 cycles with `src1`=4567. Required: `sel`=1 exactly 2+4+1 cycles after `btn` rises, then `num`=4567 with `update`=1 one cycle later.
- Bounce: toggle `btn` high for 3 cycles, then low for 1, repeated 5 times. Required: `sel` stays 0 and there is no forced `update`.
- Saturation: select `src2`=32'h0001_0000. Required: `num`=8191, `sat`=1. Then set `src2`=9. Required: at the next periodic load, `num`=9, `sat`=0.
- Freeze: set `freeze`=1 and then press. Required: `sel` advances to 1 but `num` holds for 20 cycles with no `update`. Drop `freeze`. Required: `num`=`src1` on the next edge.
- Wrap and collision: perform four presses. Required: `sel` goes 1, 2, 3, 0. Time one press so the `sel` edge coincides with `upd_cnt`=7. Required: two consecutive `update` pulses, the first showing the old source and the second the new one.

Source files
------------

// File: rtl/seg_display_source_select.sv
// Debounced source selector feeding the four-digit seven-segment driver.
// Samples one of four 32-bit values periodically or on selection change.
module seg_display_source_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int UPDATE_CYCLES   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn,
  input  logic        freeze,
  input  logic [31:0] src0,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [31:0] src3,
  output logic [12:0] num,
  output logic [1:0]  sel,
  output logic        sat,
  output logic        update
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int UW = $clog2(UPDATE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [UW-1:0] UP_LAST = UW'(UPDATE_CYCLES - 1);
  localparam logic [31:0]   NUM_MAX = 32'd8191;

  logic          sync1;
  logic          btn_s;
  logic          btn_q;
  logic          btn_q_d;
  logic [DW-1:0] db_cnt;
  logic [UW-1:0] upd_cnt;
  logic          load_pend;

  logic          press;
  logic          upd_term;
  logic          forced;
  logic          load;
  logic [31:0]   src_sel;

  assign press    = btn_q & ~btn_q_d;
  assign upd_term = (upd_cnt == UP_LAST);
  assign forced   = load_pend & ~freeze;
  assign load     = ~freeze & (upd_term | load_pend);

  always_comb begin
    src_sel = src0;
    unique case (sel)
      2'd0: src_sel = src0;
      2'd1: src_sel = src1;
      2'd2: src_sel = src2;
      2'd3: src_sel = src3;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      btn_q   <= 1'b0;
      btn_q_d <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1   <= btn;
      btn_s   <= sync1;
      btn_q_d <= btn_q;
      if (btn_s == btn_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_q  <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end
    end
  end

  // A press on a load edge re-arms load_pend so the new index follows
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel       <= 2'd0;
      load_pend <= 1'b0;
    end else begin
      if (press) begin
        sel       <= sel + 2'd1;
        load_pend <= 1'b1;
      end else if (forced) begin
        load_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      upd_cnt <= '0;
    end else if (forced || upd_term) begin
      upd_cnt <= '0;
    end else begin
      upd_cnt <= upd_cnt + UW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num    <= 13'd0;
      sat    <= 1'b0;
      update <= 1'b0;
    end else begin
      update <= load;
      if (load) begin
        sat <= (src_sel > NUM_MAX);
        num <= (src_sel > NUM_MAX) ? 13'h1FFF : src_sel[12:0];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_source_select.sv
// Directed bench for seg_display_source_select with short
// debounce and update periods.
module tb_seg_display_source_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn;
  logic        freeze;
  logic [31:0] src0, src1, src2, src3;
  logic [12:0] num;
  logic [1:0]  sel;
  logic        sat;
  logic        update;

  int cmp = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] v;
    logic [12:0] n;
    logic        s;
  } vec_t;

  vec_t tbl[6];

  seg_display_source_select #(
    .DEBOUNCE_CYCLES(4),
    .UPDATE_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .freeze(freeze),
    .src0(src0),
    .src1(src1),
    .src2(src2),
    .src3(src3),
    .num(num),
    .sel(sel),
    .sat(sat),
    .update(update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_update(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!update && n < 20);
    chk(nm, {31'd0, update}, 32'd1);
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    int since, nupd, bad_b;

    tbl[0] = '{v: 32'd9,          n: 13'd9,    s: 1'b0};
    tbl[1] = '{v: 32'd8191,       n: 13'd8191, s: 1'b0};
    tbl[2] = '{v: 32'd8192,       n: 13'd8191, s: 1'b1};
    tbl[3] = '{v: 32'hFFFF_FFFF,  n: 13'd8191, s: 1'b1};
    tbl[4] = '{v: 32'd0,          n: 13'd0,    s: 1'b0};
    tbl[5] = '{v: 32'd1234,       n: 13'd1234, s: 1'b0};

    rst = 1'b0;
    btn = 1'b0;
    freeze = 1'b0;
    src0 = 32'd123;
    src1 = 32'd4567;
    src2 = 32'h0001_0000;
    src3 = 32'd777;

    // Reset state and first periodic load
    repeat (3) tick();
    chk("rst_num", {19'd0, num}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_sat", {31'd0, sat}, 32'd0);
    chk("rst_upd", {31'd0, update}, 32'd0);
    rst = 1'b1;
    nupd = 0;
    repeat (7) begin
      tick();
      if (update) nupd++;
    end
    chk("early_upd", nupd, 32'd0);
    tick();
    chk("first_upd", {31'd0, update}, 32'd1);
    chk("first_num", {19'd0, num}, 32'd123);

    // Bounce: glitches shorter than the debounce window
    since = 0;
    nupd = 0;
    bad_b = 0;
    for (int r = 0; r < 30; r++) begin
      if (r < 20) btn = ((r % 4) != 3);
      else btn = 1'b0;
      tick();
      since++;
      if (sel !== 2'd0) bad_b++;
      if (update) begin
        nupd++;
        if (since % 8 != 0) bad_b++;
      end
    end
    chk("bounce_bad", bad_b, 32'd0);
    chk("bounce_nupd", nupd, 32'd3);
    chk("bounce_sel", {30'd0, sel}, 32'd0);

    // Clean press: sel after 7 edges, forced load one edge later
    wait_update("anchor1");
    tick();
    tick();
    btn = 1'b1;
    repeat (6) tick();
    chk("press_sel_pre", {30'd0, sel}, 32'd0);
    tick();
    chk("press_sel", {30'd0, sel}, 32'd1);
    chk("press_upd0", {31'd0, update}, 32'd0);
    tick();
    chk("press_upd1", {31'd0, update}, 32'd1);
    chk("press_num", {19'd0, num}, 32'd4567);
    chk("press_sat", {31'd0, sat}, 32'd0);
    repeat (2) tick();
    btn = 1'b0;
    repeat (8) tick();

    // Saturation on selection, then table of periodic loads
    press();
    chk("sat_sel", {30'd0, sel}, 32'd2);
    chk("sat_num", {19'd0, num}, 32'd8191);
    chk("sat_flag", {31'd0, sat}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      src2 = tbl[i].v;
      wait_update($sformatf("tbl%0d_upd", i));
      chk($sformatf("tbl%0d_num", i), {19'd0, num}, {19'd0, tbl[i].n});
      chk($sformatf("tbl%0d_sat", i), {31'd0, sat}, {31'd0, tbl[i].s});
    end

    // Freeze: sel advances, num holds, forced load on release
    freeze = 1'b1;
    press();
    nupd = 0;
    bad_b = 0;
    repeat (20) begin
      tick();
      if (update) nupd++;
      if (num !== 13'd1234) bad_b++;
    end
    chk("frz_sel", {30'd0, sel}, 32'd3);
    chk("frz_nupd", nupd, 32'd0);
    chk("frz_hold", bad_b, 32'd0);
    freeze = 1'b0;
    tick();
    chk("frz_rel_upd", {31'd0, update}, 32'd1);
    chk("frz_rel_num", {19'd0, num}, 32'd777);

    // Wrap 3 -> 0
    src0 = 32'd55;
    press();
    chk("wrap_sel", {30'd0, sel}, 32'd0);
    chk("wrap_num", {19'd0, num}, 32'd55);

    // Collision: sel edge on the periodic terminal edge
    src1 = 32'd66;
    wait_update("anchor2");
    tick();
    btn = 1'b1;
    repeat (7) tick();
    chk("col_sel", {30'd0, sel}, 32'd1);
    chk("col_upd0", {31'd0, update}, 32'd1);
    chk("col_num0", {19'd0, num}, 32'd55);
    tick();
    chk("col_upd1", {31'd0, update}, 32'd1);
    chk("col_num1", {19'd0, num}, 32'd66);
    tick();
    chk("col_upd2", {31'd0, update}, 32'd0);
    tick();
    btn = 1'b0;
    repeat (8) tick();

    // Reset mid-debounce discards progress
    btn = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_sel", {30'd0, sel}, 32'd0);
    chk("mid_rst_num", {19'd0, num}, 32'd0);
    btn = 1'b0;
    rst = 1'b1;
    repeat (10) tick();
    chk("post_rst_sel", {30'd0, sel}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
